// File: rtl/mlaccel_pkg.sv
// rtl/mlaccel_pkg.sv - opcodes, status bit positions and FSM encoding for the command sequencer
package mlaccel_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h20;
    localparam logic [7:0] CMD_WRBUF  = 8'h21;
    localparam logic [7:0] CMD_RDBUF  = 8'h22;
    localparam logic [7:0] CMD_DMA_WR = 8'h23;
    localparam logic [7:0] CMD_DMA_RD = 8'h24;
    localparam logic [7:0] CMD_RUN    = 8'h25;

    localparam int STAT_ERR  = 7;
    localparam int STAT_CORE = 1;
    localparam int STAT_DMA  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ARG    = 3'd2,
        ST_WRBUF  = 3'd3,
        ST_RDBUF  = 3'd4,
        ST_STATUS = 3'd5,
        ST_DRAIN  = 3'd6
    } state_t;

endpackage

// File: rtl/mlaccel_cmdseq.sv
// rtl/mlaccel_cmdseq.sv - host command sequencer: buffer access, DMA and kernel launch
module mlaccel_cmdseq
    import mlaccel_pkg::*;
#(
    parameter int BUF_AW = 10,
    parameter int MEM_AW = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_start,
    input  logic              rx_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    input  logic              tx_ack,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_waddr,
    output logic [7:0]        buf_wdata,
    output logic [BUF_AW-1:0] buf_raddr,
    input  logic [7:0]        buf_rdata,
    output logic              dma_start,
    output logic              dma_dir,
    output logic [MEM_AW-1:0] dma_addr,
    output logic [8:0]        dma_nwords,
    input  logic              dma_busy,
    output logic              run_start,
    output logic [MEM_AW-1:0] run_addr,
    input  logic              core_busy,
    output logic              err
);

    state_t     state;
    logic [7:0] op;
    logic [7:0] arg0;
    logic [7:0] arg1;
    logic [1:0] arg_cnt;
    logic [7:0] status_byte;
    logic       any_busy;

    assign any_busy = dma_busy | core_busy;

    // dma_start counts as busy so the host never sees 0x00 before the engine reacts
    always_comb begin
        status_byte            = 8'h00;
        status_byte[STAT_ERR]  = err;
        status_byte[STAT_CORE] = core_busy;
        status_byte[STAT_DMA]  = dma_busy | dma_start;
    end

    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_STATUS: tx_data = status_byte;
            ST_RDBUF:  tx_data = buf_rdata;
            default:   tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op         <= 8'h00;
            arg0       <= 8'h00;
            arg1       <= 8'h00;
            arg_cnt    <= 2'd0;
            buf_we     <= 1'b0;
            buf_waddr  <= '0;
            buf_wdata  <= 8'h00;
            buf_raddr  <= '0;
            dma_start  <= 1'b0;
            dma_dir    <= 1'b0;
            dma_addr   <= '0;
            dma_nwords <= 9'd0;
            run_start  <= 1'b0;
            run_addr   <= '0;
            err        <= 1'b0;
        end else begin
            dma_start <= 1'b0;
            run_start <= 1'b0;
            buf_we    <= 1'b0;
            if (buf_we)
                buf_waddr <= buf_waddr + BUF_AW'(1);
            // clear first so any error raised in the same cycle is kept
            if (state == ST_STATUS && tx_ack && status_byte[STAT_ERR])
                err <= 1'b0;

            if (rx_start) begin
                state     <= ST_CMD;
                buf_waddr <= '0;
                buf_raddr <= '0;
                arg_cnt   <= 2'd0;
            end else if (rx_end) begin
                state   <= ST_IDLE;
                arg_cnt <= 2'd0;
            end else begin
                case (state)
                    ST_CMD: if (rx_valid) begin
                        op      <= rx_data;
                        arg_cnt <= 2'd0;
                        case (rx_data)
                            CMD_STATUS: state <= ST_STATUS;
                            CMD_WRBUF:  state <= ST_WRBUF;
                            CMD_RDBUF:  state <= ST_RDBUF;
                            CMD_DMA_WR, CMD_DMA_RD, CMD_RUN: state <= ST_ARG;
                            default: begin
                                state <= ST_DRAIN;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                    ST_ARG: if (rx_valid) begin
                        arg_cnt <= arg_cnt + 2'd1;
                        case (arg_cnt)
                            2'd0: arg0 <= rx_data;
                            2'd1: begin
                                arg1 <= rx_data;
                                if (op == CMD_RUN) begin
                                    state <= ST_DRAIN;
                                    if (any_busy) begin
                                        err <= 1'b1;
                                    end else begin
                                        run_start <= 1'b1;
                                        run_addr  <= MEM_AW'({rx_data, arg0});
                                    end
                                end
                            end
                            default: begin
                                state <= ST_STATUS;
                                if (any_busy) begin
                                    err <= 1'b1;
                                end else begin
                                    dma_start  <= 1'b1;
                                    dma_dir    <= (op == CMD_DMA_RD);
                                    dma_addr   <= MEM_AW'({arg1, arg0});
                                    dma_nwords <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                                end
                            end
                        endcase
                    end
                    ST_WRBUF: if (rx_valid) begin
                        buf_we    <= 1'b1;
                        buf_wdata <= rx_data;
                        if (dma_busy)
                            err <= 1'b1;
                    end
                    ST_RDBUF: if (tx_ack) begin
                        buf_raddr <= buf_raddr + BUF_AW'(1);
                        if (dma_busy)
                            err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mlaccel_cmdseq.sv
// tb/tb_mlaccel_cmdseq.sv - scoreboard bench for the command sequencer
module tb_mlaccel_cmdseq;
    import mlaccel_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_start = 1'b0;
    logic        rx_end = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_ack = 1'b0;
    logic        buf_we;
    logic [9:0]  buf_waddr;
    logic [7:0]  buf_wdata;
    logic [9:0]  buf_raddr;
    logic [7:0]  buf_rdata;
    logic        dma_start;
    logic        dma_dir;
    logic [15:0] dma_addr;
    logic [8:0]  dma_nwords;
    logic        dma_busy;
    logic        run_start;
    logic [15:0] run_addr;
    logic        core_busy = 1'b0;
    logic        err;

    mlaccel_cmdseq #(.BUF_AW(10), .MEM_AW(16)) dut (
        .clock(clock), .reset(reset),
        .rx_start(rx_start), .rx_end(rx_end), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_ack(tx_ack),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .dma_start(dma_start), .dma_dir(dma_dir), .dma_addr(dma_addr),
        .dma_nwords(dma_nwords), .dma_busy(dma_busy),
        .run_start(run_start), .run_addr(run_addr), .core_busy(core_busy),
        .err(err)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic dir; logic [15:0] addr; logic [8:0] n; } dma_t;

    wr_t        wr_q[$];
    dma_t       dma_q[$];
    logic [15:0] run_q[$];
    logic [7:0] tx_q[$];
    wr_t        wr_e;
    dma_t       dma_e;
    logic [15:0] run_e;
    logic [7:0] tx_e;

    int n_checks = 0;
    int n_fail = 0;
    int dma_seen = 0;
    int run_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // transfer buffer with one-cycle read latency
    logic [7:0] bmem [0:1023];
    always @(posedge clock) begin
        if (buf_we) bmem[buf_waddr] <= buf_wdata;
        buf_rdata <= bmem[buf_raddr];
    end

    // copy engine: busy for a fixed time after each launch
    logic [4:0] dma_left;
    assign dma_busy = (dma_left != 5'd0);
    always @(posedge clock or posedge reset) begin
        if (reset) dma_left <= 5'd0;
        else if (dma_start) dma_left <= 5'd12;
        else if (dma_left != 5'd0) dma_left <= dma_left - 5'd1;
    end

    always @(negedge clock) begin
        if (!reset && buf_we) begin
            if (wr_q.size() == 0) check("wr_unexpected", 32'(buf_waddr), 32'hFFFF_FFFF);
            else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(buf_waddr), 32'(wr_e.a));
                check("wr_data", 32'(buf_wdata), 32'(wr_e.d));
            end
        end
        if (!reset && dma_start) begin
            dma_seen++;
            if (dma_q.size() == 0) check("dma_unexpected", 32'(dma_addr), 32'hFFFF_FFFF);
            else begin
                dma_e = dma_q.pop_front();
                check("dma_dir", 32'(dma_dir), 32'(dma_e.dir));
                check("dma_addr", 32'(dma_addr), 32'(dma_e.addr));
                check("dma_nwords", 32'(dma_nwords), 32'(dma_e.n));
            end
        end
        if (!reset && run_start) begin
            run_seen++;
            if (run_q.size() == 0) check("run_unexpected", 32'(run_addr), 32'hFFFF_FFFF);
            else begin
                run_e = run_q.pop_front();
                check("run_addr", 32'(run_addr), 32'(run_e));
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        tick;
    endtask

    task automatic txn_start;
        rx_start = 1'b1; tick; rx_start = 1'b0; tick;
    endtask

    task automatic txn_end;
        rx_end = 1'b1; tick; rx_end = 1'b0; tick;
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        check(tag, 32'(tx_data), 32'(exp));
        tx_ack = 1'b1; tick; tx_ack = 1'b0; tick;
    endtask

    task automatic wait_dma_idle;
        int n;
        n = 0;
        while (dma_busy && n < 200) begin
            tick;
            n++;
        end
        check("dma_idle_timeout", 32'(dma_busy), 32'd0);
    endtask

    initial begin
        repeat (3) tick;
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_err", 32'(err), 32'd0);
        check("rst_waddr", 32'(buf_waddr), 32'd0);
        check("rst_dma_addr", 32'(dma_addr), 32'd0);
        reset = 1'b0;
        tick;

        // buffer write burst
        txn_start;
        send_byte(CMD_WRBUF);
        for (int i = 0; i < 8; i++) begin
            wr_q.push_back({10'(i), 8'(i + 1)});
            send_byte(8'(i + 1));
        end
        txn_end;
        check("wr_drained", 32'(wr_q.size()), 32'd0);

        // buffer -> memory copy, status polled in the same transaction
        txn_start;
        dma_q.push_back({1'b0, 16'h0200, 9'd1});
        send_byte(CMD_DMA_WR); send_byte(8'h00); send_byte(8'h02); send_byte(8'h01);
        read_status("st_dma_busy", 8'h01);
        wait_dma_idle;
        read_status("st_dma_done", 8'h00);
        txn_end;

        // memory -> buffer copy, length 0 means 256 words
        txn_start;
        dma_q.push_back({1'b1, 16'h0010, 9'd256});
        send_byte(CMD_DMA_RD); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        read_status("st_dma2_busy", 8'h01);
        txn_end;
        wait_dma_idle;

        // buffer readback
        txn_start;
        send_byte(CMD_WRBUF);
        wr_q.push_back({10'd0, 8'hAA}); send_byte(8'hAA);
        wr_q.push_back({10'd1, 8'hBB}); send_byte(8'hBB);
        wr_q.push_back({10'd2, 8'hCC}); send_byte(8'hCC);
        txn_end;
        txn_start;
        send_byte(CMD_RDBUF);
        tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
        for (int i = 0; i < 3; i++) begin
            tx_e = tx_q.pop_front();
            check("rd_byte", 32'(tx_data), 32'(tx_e));
            tx_ack = 1'b1; tick; tx_ack = 1'b0; tick;
        end
        txn_end;

        // kernel run refused while core busy
        core_busy = 1'b1;
        txn_start;
        send_byte(CMD_RUN); send_byte(8'h00); send_byte(8'h00);
        txn_end;
        check("run_refused", 32'(run_seen), 32'd0);
        txn_start;
        send_byte(CMD_STATUS);
        read_status("st_busy_err", 8'h82);
        read_status("st_err_clr", 8'h02);
        txn_end;
        core_busy = 1'b0;

        // kernel run accepted
        txn_start;
        run_q.push_back(16'h1234);
        send_byte(CMD_RUN); send_byte(8'h34); send_byte(8'h12);
        check("tx_drain", 32'(tx_data), 32'h00);
        txn_end;
        check("run_once", 32'(run_seen), 32'd1);

        // aborted argument collection
        txn_start;
        send_byte(CMD_DMA_WR); send_byte(8'h00);
        txn_end;
        check("abort_state", 32'(dut.state), 32'(ST_IDLE));
        check("abort_no_dma", 32'(dma_seen), 32'd2);
        check("abort_tx", 32'(tx_data), 32'h00);

        // byte coinciding with rx_end is dropped
        txn_start;
        send_byte(CMD_WRBUF);
        rx_data = 8'h55; rx_valid = 1'b1; rx_end = 1'b1;
        tick;
        rx_valid = 1'b0; rx_end = 1'b0;
        tick; tick;
        check("end_wins_state", 32'(dut.state), 32'(ST_IDLE));

        // bad opcode
        txn_start;
        send_byte(8'h7F);
        check("bad_op_err", 32'(err), 32'd1);
        txn_end;
        txn_start;
        send_byte(CMD_STATUS);
        read_status("st_bad_op", 8'h80);
        read_status("st_bad_clr", 8'h00);
        txn_end;

        // buffer write during DMA flags contention but still writes
        txn_start;
        dma_q.push_back({1'b0, 16'h0000, 9'd2});
        send_byte(CMD_DMA_WR); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        txn_end;
        txn_start;
        send_byte(CMD_WRBUF);
        wr_q.push_back({10'd0, 8'h11});
        send_byte(8'h11);
        check("contention_err", 32'(err), 32'd1);
        txn_end;
        wait_dma_idle;
        txn_start;
        send_byte(CMD_STATUS);
        read_status("st_contention", 8'h80);
        txn_end;

        // reset mid-transaction abandons it
        txn_start;
        send_byte(CMD_DMA_RD); send_byte(8'h01);
        reset = 1'b1; tick; reset = 1'b0; tick;
        check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        send_byte(8'h02); send_byte(8'h03);
        check("midrst_no_dma", 32'(dma_seen), 32'd3);

        check("q_wr_empty", 32'(wr_q.size()), 32'd0);
        check("q_dma_empty", 32'(dma_q.size()), 32'd0);
        check("q_run_empty", 32'(run_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
